// File: rtl/rv_data_memory_if.sv
// Load/store bus between the RV32 core's data port and the data memory.
// The core drives address/data/control; the memory returns the registered load result.
interface rv_data_memory_if;
  logic [31:0] addr;
  logic [31:0] din;
  logic [2:0]  memOp;
  logic        we;
  logic        re;
  logic [31:0] dout;

  modport master (output addr, output din, output memOp, output we, output re, input dout);
  modport slave  (input addr, input din, input memOp, input we, input re, output dout);
endinterface

// File: rtl/rv_data_memory.sv
// Byte-addressable RV32 data memory: lane-enabled stores, sign/zero-extended loads.
// Load result registered one cycle after re; no backpressure, every request completes.
module rv_data_memory #(
  parameter int WORD_ADDR_WIDTH = 15
) (
  input  logic              clock,
  input  logic              reset,
  rv_data_memory_if.slave   bus
);
  localparam int DEPTH = 2 ** WORD_ADDR_WIDTH;

  logic [3:0][7:0] mem_array [DEPTH];

  logic [WORD_ADDR_WIDTH-1:0] word_idx;
  logic [1:0]                 lane;
  logic [3:0]                 lane_en;
  logic [3:0][7:0]            wr_data;
  logic [3:0][7:0]            rd_word;
  logic [7:0]                 rd_byte;
  logic [15:0]                rd_half;
  logic [31:0]                ld_val;
  logic                       unused_addr_bits;

  // Upper address bits are dropped so accesses wrap around the array.
  assign word_idx         = bus.addr[WORD_ADDR_WIDTH+1:2];
  assign lane             = bus.addr[1:0];
  assign unused_addr_bits = &{1'b0, bus.addr[31:WORD_ADDR_WIDTH+2]};

  always_comb begin
    lane_en = 4'b0000;
    wr_data = bus.din;
    case (bus.memOp)
      3'b000, 3'b100: begin
        lane_en = 4'b0001 << lane;
        wr_data = {4{bus.din[7:0]}};
      end
      3'b001, 3'b101: begin
        lane_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.din[15:0]}};
      end
      3'b010: begin
        lane_en = 4'b1111;
        wr_data = bus.din;
      end
      default: lane_en = 4'b0000;
    endcase
  end

  // Array is not reset; the read below sees pre-write contents on a same-edge store.
  always_ff @(posedge clock) begin
    if (!reset && bus.we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem_array[word_idx][i] <= wr_data[i];
      end
    end
  end

  always_comb begin
    rd_word = mem_array[word_idx];
    rd_byte = rd_word[lane];
    rd_half = lane[1] ? rd_word[3:2] : rd_word[1:0];
    ld_val  = 32'h0;
    case (bus.memOp)
      3'b000:  ld_val = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ld_val = {24'h0, rd_byte};
      3'b001:  ld_val = {{16{rd_half[15]}}, rd_half};
      3'b101:  ld_val = {16'h0, rd_half};
      3'b010:  ld_val = rd_word;
      default: ld_val = 32'h0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.dout <= 32'h0;
    end else if (bus.re) begin
      bus.dout <= ld_val;
    end
  end
endmodule

// File: tb/tb_rv_data_memory.sv
// Directed bench for rv_data_memory: word-level reference model plus literal checks.
module tb_rv_data_memory;
  localparam int WAW = 15;
  localparam logic [31:0] SPAN = 32'h1 << (WAW + 2);

  logic clock;
  logic reset;
  rv_data_memory_if bus ();

  rv_data_memory #(.WORD_ADDR_WIDTH(WAW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem_m [int];
  logic [31:0] exp_dout;
  bit          exp_known = 1'b0;

  function automatic int widx(input logic [31:0] a);
    return int'((a % SPAN) / 4);
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] d,
                                          input logic [2:0] op, input logic [31:0] a);
    int sh;
    logic [31:0] m;
    case (op)
      3'd0, 3'd4: begin
        sh = 8 * int'(a % 4);
        m  = 32'hFF << sh;
        return (w & ~m) | ((d & 32'hFF) << sh);
      end
      3'd1, 3'd5: begin
        sh = ((a % 4) >= 2) ? 16 : 0;
        m  = 32'hFFFF << sh;
        return (w & ~m) | ((d & 32'hFFFF) << sh);
      end
      3'd2:    return d;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] op,
                                         input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * int'(a % 4))) & 32'hFF;
    h = ((a % 4) >= 2) ? (w >> 16) : (w & 32'hFFFF);
    case (op)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd5:    return h;
      3'd2:    return w;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clock) begin
    if (exp_known) begin
      n_tests++;
      if (bus.dout !== exp_dout) begin
        n_fail++;
        $display("FAIL model_dout t=%0t got=%08h want=%08h", $time, bus.dout, exp_dout);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] want);
    n_tests++;
    if (bus.dout !== want) begin
      n_fail++;
      $display("FAIL %s got=%08h want=%08h", name, bus.dout, want);
    end
  endtask

  // One request edge; model updated with the same inputs, load before store.
  task automatic cyc(input bit w, input bit r, input logic [31:0] a,
                     input logic [31:0] d, input logic [2:0] op);
    int i;
    bus.addr = a; bus.din = d; bus.memOp = op; bus.we = w; bus.re = r;
    @(posedge clock);
    if (!reset) begin
      i = widx(a);
      if (r) begin
        if (mem_m.exists(i)) begin
          exp_dout  = m_load(mem_m[i], op, a);
          exp_known = 1'b1;
        end else if (op == 3'd3 || op >= 3'd6) begin
          exp_dout  = 32'h0;
          exp_known = 1'b1;
        end else begin
          exp_known = 1'b0;
        end
      end
      if (w) begin
        if (mem_m.exists(i)) mem_m[i] = m_store(mem_m[i], d, op, a);
        else if (op == 3'd2) mem_m[i] = d;
      end
    end
    #1;
    bus.we = 1'b0; bus.re = 1'b0;
  endtask

  initial begin
    bus.addr = '0; bus.din = '0; bus.memOp = 3'd2; bus.we = 1'b0; bus.re = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    exp_dout = 32'h0; exp_known = 1'b1;
    #1 chk("reset_state", 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;

    cyc(1, 0, 32'h100, 32'h12345678, 3'd2);
    cyc(0, 1, 32'h100, 32'h0, 3'd2);        chk("lw_100", 32'h12345678);
    cyc(0, 1, 32'h103, 32'h0, 3'd2);        chk("lw_103", 32'h12345678);
    cyc(1, 0, 32'h101, 32'h000000AB, 3'd0);
    cyc(0, 1, 32'h100, 32'h0, 3'd2);        chk("sb_lw_100", 32'h1234AB78);
    cyc(0, 1, 32'h101, 32'h0, 3'd0);        chk("lb_101", 32'hFFFFFFAB);
    cyc(0, 1, 32'h101, 32'h0, 3'd4);        chk("lbu_101", 32'h000000AB);
    cyc(0, 1, 32'h102, 32'h0, 3'd0);        chk("lb_102", 32'h00000034);

    cyc(1, 0, 32'h200, 32'h11111111, 3'd2);
    cyc(1, 0, 32'h202, 32'h0000F00D, 3'd1);
    cyc(0, 1, 32'h200, 32'h0, 3'd2);        chk("sh_lw_200", 32'hF00D1111);
    cyc(0, 1, 32'h202, 32'h0, 3'd1);        chk("lh_202", 32'hFFFFF00D);
    cyc(0, 1, 32'h203, 32'h0, 3'd5);        chk("lhu_203", 32'h0000F00D);
    cyc(0, 1, 32'h200, 32'h0, 3'd1);        chk("lh_200", 32'h00001111);

    cyc(1, 0, 32'h300, 32'h0, 3'd2);
    cyc(1, 1, 32'h300, 32'hCAFEBABE, 3'd2); chk("read_first", 32'h0);
    cyc(0, 1, 32'h300, 32'h0, 3'd2);        chk("after_write", 32'hCAFEBABE);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 32'h100, 32'h0, 3'd0);      chk("hold_re0", 32'hCAFEBABE);
    end

    cyc(1, 0, 32'h400, 32'h22222222, 3'd2);
    cyc(1, 0, 32'h400, 32'hFFFFFFFF, 3'd7);
    cyc(0, 1, 32'h400, 32'h0, 3'd2);        chk("inv_store", 32'h22222222);
    cyc(0, 1, 32'h400, 32'h0, 3'd3);        chk("inv_load", 32'h0);

    cyc(1, 0, 32'h20000, 32'h55AA55AA, 3'd2);
    cyc(0, 1, 32'h0, 32'h0, 3'd2);          chk("wrap", 32'h55AA55AA);

    cyc(1, 0, 32'h500, 32'hDEADBEEF, 3'd2);
    cyc(0, 1, 32'h500, 32'h0, 3'd2);        chk("pre_reset", 32'hDEADBEEF);
    @(negedge clock);
    #2 reset = 1'b1;
    exp_dout = 32'h0;
    #1 chk("async_reset", 32'h0);
    cyc(1, 1, 32'h500, 32'h0, 3'd2);        chk("load_in_reset", 32'h0);
    @(negedge clock) reset = 1'b0;
    cyc(0, 1, 32'h500, 32'h0, 3'd2);        chk("array_kept", 32'hDEADBEEF);
    cyc(0, 0, 32'h0, 32'h0, 3'd2);

    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
